// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_pkg
// Shared definitions for the synchronous FIFO family:
//   - read-mode selectors (standard / first-word-fall-through)
//   - helpers that derive depth and pointer widths from the address width
// No ports; imported by sync_fifo_param and its memory sub-module.
// -----------------------------------------------------------------------------
package sync_fifo_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Number of words addressed by an address of ptr_w bits.
  function automatic int fifo_depth(input int ptr_w);
    return 1 << ptr_w;
  endfunction

  // Pointers carry one extra wrap bit so full and empty remain distinguishable.
  function automatic int fifo_ptr_width(input int ptr_w);
    return ptr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem_dp.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_mem_dp
// DEPTH x DWIDTH register array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module sync_fifo_param_mem_dp
  import sync_fifo_param_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int PTRWIDTH = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [PTRWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [PTRWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0]   rdata
);

  localparam int DEPTH = fifo_depth(PTRWIDTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with standard or first-word-fall-through
// read mode, fill count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
// Ports:
//   clk           in   rising-edge clock
//   reset_L       in   asynchronous active-low reset
//   clr           in   synchronous flush (wins over push/pop, clears flags)
//   push, wdata   in   write request / data
//   full          out  count == DEPTH
//   almost_full   out  count >= AF_LEVEL
//   pop           in   read request
//   rdata         out  read data (registered in std mode, head word in FWFT)
//   empty         out  count == 0
//   almost_empty  out  count <= AE_LEVEL
//   count         out  words stored, 0..DEPTH
//   overflow      out  sticky: push seen while full
//   underflow     out  sticky: pop seen while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int PTRWIDTH = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              clr,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  output logic              full,
  output logic              almost_full,
  input  logic              pop,
  output logic [DWIDTH-1:0] rdata,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTRWIDTH:0] count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = fifo_depth(PTRWIDTH);
  localparam int PW    = fifo_ptr_width(PTRWIDTH);

  localparam logic [PTRWIDTH:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [PTRWIDTH:0] AF_CNT    = PW'(AF_LEVEL);
  localparam logic [PTRWIDTH:0] AE_CNT    = PW'(AE_LEVEL);
  localparam logic [PTRWIDTH:0] PTR_ONE   = PW'(1);

  if (PTRWIDTH < 1) begin : g_chk_ptr
    $fatal(1, "sync_fifo_param: PTRWIDTH must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $fatal(1, "sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_chk_mode
    $fatal(1, "sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [PTRWIDTH:0] wrptr;
  logic [PTRWIDTH:0] rdptr;
  logic              wr_en;
  logic              rd_en;
  logic [DWIDTH-1:0] mem_rdata;

  // Modular subtraction of the wrap-extended pointers yields 0..DEPTH.
  assign count        = wrptr - rdptr;
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Flush suppresses both ports so nothing lands in memory that cycle.
  assign wr_en = push && !full  && !clr;
  assign rd_en = pop  && !empty && !clr;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wrptr     <= '0;
      rdptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wrptr     <= '0;
      rdptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wrptr <= wrptr + PTR_ONE;
      if (rd_en) rdptr <= rdptr + PTR_ONE;
      if (push && full)  overflow  <= 1'b1;
      if (pop  && empty) underflow <= 1'b1;
    end
  end

  sync_fifo_param_mem_dp #(
    .DWIDTH   (DWIDTH),
    .PTRWIDTH (PTRWIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wrptr[PTRWIDTH-1:0]),
    .wdata (wdata),
    .raddr (rdptr[PTRWIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is shown directly; forced to zero when empty so the output
    // never exposes uninitialised memory.
    assign rdata = empty ? '0 : mem_rdata;
  end else begin : g_std
    logic [DWIDTH-1:0] rdata_q;

    // Holds across flush; only an accepted pop updates it.
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        rdata_q <= '0;
      end else if (rd_en) begin
        rdata_q <= mem_rdata;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param: one standard-mode instance (u_dut) and
// one FWFT instance (u_fwft), both DEPTH=16, sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic       clk;
  logic       reset_L;

  logic       clr, push, pop;
  logic [7:0] wdata;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [7:0] rdata;
  logic [4:0] count;

  logic       f_clr, f_push, f_pop;
  logic [7:0] f_wdata;
  logic       f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;
  logic [7:0] f_rdata;
  logic [4:0] f_count;

  int errors = 0;
  int checks = 0;

  sync_fifo_param #(.DWIDTH(8), .PTRWIDTH(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut (
    .clk(clk), .reset_L(reset_L), .clr(clr), .push(push), .wdata(wdata),
    .full(full), .almost_full(almost_full), .pop(pop), .rdata(rdata),
    .empty(empty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DWIDTH(8), .PTRWIDTH(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
    .clk(clk), .reset_L(reset_L), .clr(f_clr), .push(f_push), .wdata(f_wdata),
    .full(f_full), .almost_full(f_almost_full), .pop(f_pop), .rdata(f_rdata),
    .empty(f_empty), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; push = 0; pop = 0; wdata = 8'h00;
  endtask

  task automatic do_clr();
    idle();
    clr = 1;
    step();
    clr = 0;
  endtask

  task automatic test_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
    checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft_empty got=%b exp=1", f_empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      idle();
      push = 1; wdata = 8'(i);
      step();
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= 14)); end
      checks++; if (almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, almost_empty, (i + 1 <= 2)); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
    push = 1; wdata = 8'hEE;
    step();
    idle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_ovf_count got=%0d exp=16", count); end
  endtask

  task automatic test_drain_std();
    for (int i = 0; i < 16; i++) begin
      idle();
      pop = 1;
      step();
      checks++; if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, rdata, 8'(i)); end
      checks++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 15 - i); end
      checks++; if (almost_empty !== (15 - i <= 2)) begin errors++; $display("FAIL drain_aempty[%0d] got=%b exp=%b", i, almost_empty, (15 - i <= 2)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_no_udf got=%b exp=0", underflow); end
    pop = 1;
    step();
    idle();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_udf got=%b exp=1", underflow); end
    checks++; if (rdata !== 8'h0F) begin errors++; $display("FAIL drain_rdata_hold got=%h exp=0f", rdata); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_udf_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow); end
    do_clr();
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_flags got=%b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      idle();
      push = 1; wdata = 8'(8'h20 + i);
      step();
    end
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_start_count got=%0d exp=8", count); end
    // 40 push+pop cycles: pointers wrap twice, order must be preserved.
    for (int k = 0; k < 40; k++) begin
      idle();
      push = 1; pop = 1; wdata = 8'(8'h28 + k);
      step();
      checks++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=8", k, count); end
      checks++; if (rdata !== 8'(8'h20 + k)) begin errors++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, rdata, 8'(8'h20 + k)); end
    end
    // Queue now holds 0x48..0x4F; top up to full with 0x50..0x57.
    for (int i = 0; i < 8; i++) begin
      idle();
      push = 1; wdata = 8'(8'h50 + i);
      step();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b exp=1", full); end
    idle();
    push = 1; pop = 1; wdata = 8'hFF;
    step();
    idle();
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL b2b_full_count got=%0d exp=15", count); end
    checks++; if (rdata !== 8'h48) begin errors++; $display("FAIL b2b_full_rdata got=%h exp=48", rdata); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_full_ovf got=%b exp=1", overflow); end
    for (int i = 0; i < 15; i++) begin
      pop = 1;
      step();
    end
    idle();
    checks++; if (rdata !== 8'h57) begin errors++; $display("FAIL b2b_tail_rdata got=%h exp=57 (0xFF must be dropped)", rdata); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_tail_empty got=%b exp=1", empty); end
    do_clr();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 17; i++) begin
      idle();
      push = 1; wdata = 8'(8'h60 + i);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      pop = 1;
      step();
    end
    idle();
    checks++; if (count !== 5'd10) begin errors++; $display("FAIL flush_pre_count got=%0d exp=10", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got=%b exp=1", overflow); end
    clr = 1; push = 1; pop = 1; wdata = 8'h77;
    step();
    idle();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_udf got=%b exp=0", underflow); end
    checks++; if (rdata !== 8'h65) begin errors++; $display("FAIL flush_rdata_hold got=%h exp=65", rdata); end
    // Push+pop into an empty FIFO: push accepted, pop rejected.
    push = 1; pop = 1; wdata = 8'h33;
    step();
    idle();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL empty_pp_count got=%0d exp=1", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_pp_udf got=%b exp=1", underflow); end
    checks++; if (rdata !== 8'h65) begin errors++; $display("FAIL empty_pp_rdata got=%h exp=65", rdata); end
    pop = 1;
    step();
    idle();
    checks++; if (rdata !== 8'h33) begin errors++; $display("FAIL empty_pp_pop got=%h exp=33", rdata); end
    do_clr();
  endtask

  task automatic test_fwft();
    f_clr = 0; f_pop = 0;
    f_push = 1; f_wdata = 8'hA5;
    step();
    f_push = 0;
    checks++; if (f_empty !== 1'b0) begin errors++; $display("FAIL fwft_empty got=%b exp=0", f_empty); end
    checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_head got=%h exp=a5", f_rdata); end
    step();
    checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_head_hold got=%h exp=a5", f_rdata); end
    f_push = 1; f_wdata = 8'h3C;
    step();
    f_push = 0; f_pop = 1;
    step();
    f_pop = 0;
    checks++; if (f_rdata !== 8'h3C) begin errors++; $display("FAIL fwft_next_head got=%h exp=3c", f_rdata); end
    checks++; if (f_count !== 5'd1) begin errors++; $display("FAIL fwft_count got=%0d exp=1", f_count); end
    f_pop = 1;
    step();
    f_pop = 0;
    checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty got=%b exp=1", f_empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 17; i++) begin
      idle();
      push = 1; wdata = 8'(i);
      step();
    end
    idle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL areset_pre_ovf got=%b exp=1", overflow); end
    push = 1; wdata = 8'h11;
    reset_L = 0;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL areset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL areset_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL areset_flags got=%b exp=00", {overflow, underflow}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL areset_rdata got=%h exp=00", rdata); end
    idle();
    step();
    reset_L = 1;
    step();
  endtask

  initial begin
    reset_L = 0;
    idle();
    f_clr = 0; f_push = 0; f_pop = 0; f_wdata = 8'h00;
    #2;
    test_reset();
    step();
    step();
    reset_L = 1;
    step();
    test_fill();
    test_drain_std();
    test_back_to_back();
    test_flush();
    test_fwft();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
